// File: rtl/dm_rom_wb_bridge.sv
// Wishbone B4 pipelined slave for the debug-memory window. It serves ROM fetches
// and the FLAGS region, and turns hart writes to HALTED/GOING/RESUMING/EXCEPTION into pulses.
module dm_rom_wb_bridge #(
  parameter int unsigned AW        = 32,
  parameter int unsigned ROM_WORDS = 14
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic          wb_stall_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [31:0]   wb_dat_o,
  output logic          rom_req_o,
  output logic [63:0]   rom_addr_o,
  input  logic [63:0]   rom_rdata_i,
  input  logic          go_i,
  input  logic          resume_i,
  output logic          halted_o,
  output logic          going_o,
  output logic          resuming_o,
  output logic          exception_o,
  output logic [31:0]   hartid_o
);

  typedef enum logic [1:0] {IDLE, ROM_RD, RESP} state_e;

  localparam logic [12:0] ROM_BYTES = 13'(8 * ROM_WORDS);

  state_e      state_reg, state_next;
  logic [11:0] a;
  logic        accept;
  logic        hit_ctrl, hit_flags, hit_rom;
  logic        rom_rd, req_err;
  logic [31:0] resp_dat;
  logic [3:0]  pulse_next, pulse_reg;
  logic        hartid_we;
  logic        ack_reg, err_reg, hi_reg;
  logic [31:0] dat_reg, hartid_reg;
  logic        unused_adr;

  assign a          = wb_adr_i[11:0];
  assign unused_adr = ^wb_adr_i[AW-1:12];

  // Reset gates accept so rom_req_o stays low while rst_ni is held.
  assign accept = rst_ni & wb_cyc_i & wb_stb_i & (state_reg == IDLE);

  assign hit_ctrl  = (a[11:4] == 8'h10);
  assign hit_flags = (a[11:10] == 2'b01);
  assign hit_rom   = a[11] & ({2'b00, a[10:0]} < ROM_BYTES);

  assign rom_rd  = hit_rom & ~wb_we_i;
  assign req_err = ~(hit_ctrl | ((hit_flags | hit_rom) & ~wb_we_i));

  // Only FLAGS word 0 carries live data; everything else read outside ROM is zero.
  assign resp_dat = (~wb_we_i & hit_flags & (a[9:2] == 8'h00)) ?
                    {30'b0, resume_i, go_i} : 32'h0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pulse
    assign pulse_next[gi] = wb_we_i & (|wb_sel_i) & hit_ctrl & (a[3:2] == 2'(gi));
  end

  assign hartid_we = pulse_next[0] | pulse_next[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = rom_rd ? ROM_RD : RESP;
        end
      end
      ROM_RD:  state_next = wb_cyc_i ? RESP : IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      hi_reg     <= 1'b0;
      dat_reg    <= 32'h0;
      pulse_reg  <= 4'h0;
      hartid_reg <= 32'h0;
    end else begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      pulse_reg <= 4'h0;
      if (accept) begin
        hi_reg  <= a[2];
        dat_reg <= resp_dat;
        if (!rom_rd) begin
          ack_reg   <= ~req_err;
          err_reg   <= req_err;
          pulse_reg <= pulse_next;
        end
        if (hartid_we) begin
          hartid_reg <= wb_dat_i;
        end
      end else if (state_reg == ROM_RD && wb_cyc_i) begin
        ack_reg <= 1'b1;
        dat_reg <= hi_reg ? rom_rdata_i[63:32] : rom_rdata_i[31:0];
      end
    end
  end

  // Dropping cyc during RESP suppresses the response; registered pulses still go out.
  assign wb_stall_o  = (state_reg != IDLE);
  assign wb_ack_o    = ack_reg & wb_cyc_i;
  assign wb_err_o    = err_reg & wb_cyc_i;
  assign wb_dat_o    = wb_ack_o ? dat_reg : 32'h0;
  assign rom_req_o   = accept & rom_rd;
  assign rom_addr_o  = rom_req_o ? {52'b0, a} : 64'h0;
  assign halted_o    = pulse_reg[0];
  assign going_o     = pulse_reg[1];
  assign resuming_o  = pulse_reg[2];
  assign exception_o = pulse_reg[3];
  assign hartid_o    = hartid_reg;

endmodule

// File: tb/tb_dm_rom_wb_bridge.sv
// Scoreboard bench for dm_rom_wb_bridge: a small ROM model answers rom_req_o,
// and expected responses are queued at issue and popped when ack/err appears.
module tb_dm_rom_wb_bridge;

  localparam int ROM_WORDS = 14;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic        wb_stall_o, wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic        rom_req_o;
  logic [63:0] rom_addr_o;
  logic [63:0] rom_rdata_i;
  logic        go_i, resume_i;
  logic        halted_o, going_o, resuming_o, exception_o;
  logic [31:0] hartid_o;
  logic [3:0]  pulses;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          lat;
    logic [3:0]  pulse;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] rom_mem[16];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  assign pulses = {exception_o, resuming_o, going_o, halted_o};

  dm_rom_wb_bridge #(.AW(32), .ROM_WORDS(ROM_WORDS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_rdata_i(rom_rdata_i), .go_i(go_i), .resume_i(resume_i),
    .halted_o(halted_o), .going_o(going_o), .resuming_o(resuming_o),
    .exception_o(exception_o), .hartid_o(hartid_o)
  );

  // ROM model: registers the address, data valid the cycle after the request.
  always @(posedge clk_i) begin
    if (rom_req_o) rom_rdata_i <= rom_mem[rom_addr_o[6:3]];
  end

  task automatic xfer(input logic we, input logic [11:0] a, input logic [3:0] sel,
                      input logic [31:0] wd, input int lat, input logic eerr,
                      input logic [31:0] edat, input logic [3:0] epulse);
    exp_t e;
    bit   seen;
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {20'h0, a}; wb_sel_i = sel; wb_dat_i = wd;
    sb.push_back('{eerr, edat, lat, epulse});
    #1;
    n_vec++;
    if (wb_stall_o !== 1'b0) begin
      n_err++; $display("FAIL stall_at_issue a=%h got=%b want=0", a, wb_stall_o);
    end
    n_vec++;
    if (rom_req_o !== (lat == 2)) begin
      n_err++; $display("FAIL rom_req a=%h got=%b want=%b", a, rom_req_o, lat == 2);
    end
    if (lat == 2) begin
      n_vec++;
      if (rom_addr_o !== {52'h0, a}) begin
        n_err++; $display("FAIL rom_addr a=%h got=%h want=%h", a, rom_addr_o, {52'h0, a});
      end
    end
    @(posedge clk_i);
    #1 wb_stb_i = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 4 && !seen; n++) begin
      @(negedge clk_i);
      if (wb_ack_o || wb_err_o) begin
        seen = 1'b1;
        e = sb.pop_front();
        n_vec++;
        if (n != e.lat) begin
          n_err++; $display("FAIL latency a=%h got=%0d want=%0d", a, n, e.lat);
        end
        n_vec++;
        if ({wb_err_o, wb_ack_o} !== {e.err, ~e.err}) begin
          n_err++; $display("FAIL resp_kind a=%h got err/ack=%b%b want=%b%b",
                            a, wb_err_o, wb_ack_o, e.err, ~e.err);
        end
        n_vec++;
        if (wb_dat_o !== (e.err ? 32'h0 : e.dat)) begin
          n_err++; $display("FAIL rdata a=%h got=%h want=%h", a, wb_dat_o, e.err ? 32'h0 : e.dat);
        end
        n_vec++;
        if (pulses !== e.pulse) begin
          n_err++; $display("FAIL pulses a=%h got=%b want=%b", a, pulses, e.pulse);
        end
      end else if (n == 1) begin
        n_vec++;
        if (rom_req_o !== 1'b0) begin
          n_err++; $display("FAIL rom_req_hold a=%h got=%b want=0", a, rom_req_o);
        end
      end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout a=%h no ack/err within 4 cycles", a);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk_i);
    n_vec++;
    if ({wb_ack_o, wb_err_o, pulses, wb_stall_o} !== 7'b0) begin
      n_err++; $display("FAIL after_resp a=%h got ack=%b err=%b pulses=%b stall=%b want all 0",
                        a, wb_ack_o, wb_err_o, pulses, wb_stall_o);
    end
    $display("xfer %s a=%h sel=%h wd=%h -> ack=%b err=%b", we ? "WR" : "RD", a, sel, wd,
             ~eerr, eerr);
    wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o, rom_req_o, rom_addr_o, pulses, hartid_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs got stall=%b ack=%b err=%b dat=%h req=%b hartid=%h want all 0",
                        wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o, rom_req_o, hartid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_rom;
    xfer(1'b0, 12'h800, 4'hF, 32'h0, 2, 1'b0, 32'h0180006F, 4'h0);
    xfer(1'b0, 12'h804, 4'hF, 32'h0, 2, 1'b0, 32'h00000013, 4'h0);
    xfer(1'b0, 12'h86C, 4'hF, 32'h0, 2, 1'b0, rom_mem[13][63:32], 4'h0);
    xfer(1'b0, 12'h830, 4'hF, 32'h0, 2, 1'b0, rom_mem[6][31:0], 4'h0);
  endtask

  task automatic test_flags;
    go_i = 1'b1; resume_i = 1'b0;
    xfer(1'b0, 12'h400, 4'hF, 32'h0, 1, 1'b0, 32'h00000001, 4'h0);
    xfer(1'b0, 12'h404, 4'hF, 32'h0, 1, 1'b0, 32'h00000000, 4'h0);
    xfer(1'b0, 12'h7FC, 4'hF, 32'h0, 1, 1'b0, 32'h00000000, 4'h0);
    go_i = 1'b0; resume_i = 1'b1;
    xfer(1'b0, 12'h400, 4'hF, 32'h0, 1, 1'b0, 32'h00000002, 4'h0);
  endtask

  task automatic test_pulses;
    xfer(1'b1, 12'h100, 4'hF, 32'h00000003, 1, 1'b0, 32'h0, 4'b0001);
    n_vec++;
    if (hartid_o !== 32'h3) begin
      n_err++; $display("FAIL hartid_halted got=%h want=00000003", hartid_o);
    end
    xfer(1'b1, 12'h10C, 4'hF, 32'h00000009, 1, 1'b0, 32'h0, 4'b1000);
    n_vec++;
    if (hartid_o !== 32'h3) begin
      n_err++; $display("FAIL hartid_exception got=%h want=00000003", hartid_o);
    end
    xfer(1'b1, 12'h104, 4'h1, 32'h00000011, 1, 1'b0, 32'h0, 4'b0010);
    xfer(1'b1, 12'h108, 4'h0, 32'h00000022, 1, 1'b0, 32'h0, 4'b0000);
    n_vec++;
    if (hartid_o !== 32'h3) begin
      n_err++; $display("FAIL hartid_sel0 got=%h want=00000003", hartid_o);
    end
    xfer(1'b1, 12'h108, 4'hC, 32'h00000005, 1, 1'b0, 32'h0, 4'b0100);
    n_vec++;
    if (hartid_o !== 32'h5) begin
      n_err++; $display("FAIL hartid_resuming got=%h want=00000005", hartid_o);
    end
    xfer(1'b0, 12'h100, 4'hF, 32'h0, 1, 1'b0, 32'h0, 4'b0000);
  endtask

  task automatic test_errors;
    xfer(1'b1, 12'h800, 4'hF, 32'hDEADBEEF, 1, 1'b1, 32'h0, 4'h0);
    xfer(1'b1, 12'h400, 4'hF, 32'h1, 1, 1'b1, 32'h0, 4'h0);
    xfer(1'b0, 12'h200, 4'hF, 32'h0, 1, 1'b1, 32'h0, 4'h0);
    xfer(1'b0, 12'h870, 4'hF, 32'h0, 1, 1'b1, 32'h0, 4'h0);
    xfer(1'b1, 12'h000, 4'hF, 32'h0, 1, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_abort;
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h808; wb_sel_i = 4'hF;
    @(posedge clk_i);
    #1 wb_stb_i = 1'b0;
    @(negedge clk_i);
    wb_cyc_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({wb_ack_o, wb_err_o, wb_stall_o} !== 3'b000) begin
      n_err++; $display("FAIL abort got ack=%b err=%b stall=%b want 000", wb_ack_o, wb_err_o, wb_stall_o);
    end
    @(negedge clk_i);
    n_vec++;
    if ({wb_ack_o, wb_err_o} !== 2'b00) begin
      n_err++; $display("FAIL abort_late got ack=%b err=%b want 00", wb_ack_o, wb_err_o);
    end
    $display("abort ROM read a=808 dropped in ROM_RD");
    xfer(1'b0, 12'h808, 4'hF, 32'h0, 2, 1'b0, rom_mem[1][31:0], 4'h0);
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk_i);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h104; wb_sel_i = 4'hF; wb_dat_i = 32'h0;
    @(posedge clk_i);
    #1 wb_stb_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({wb_ack_o, going_o} !== 2'b11) begin
      n_err++; $display("FAIL pre_reset_resp got ack=%b going=%b want 11", wb_ack_o, going_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({wb_ack_o, wb_err_o, pulses, wb_stall_o, wb_dat_o} !== '0) begin
      n_err++; $display("FAIL reset_in_resp got ack=%b err=%b pulses=%b stall=%b dat=%h want all 0",
                        wb_ack_o, wb_err_o, pulses, wb_stall_o, wb_dat_o);
    end
    wb_cyc_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    $display("reset asserted during RESP of write a=104");
    go_i = 1'b1; resume_i = 1'b1;
    xfer(1'b0, 12'h400, 4'hF, 32'h0, 1, 1'b0, 32'h00000003, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_mem[i] = {32'hA5000000 | 32'(i * 16 + 1), 32'h5A000000 | 32'(i * 16)};
    end
    rom_mem[0] = {32'h00000013, 32'h0180006F};
    rom_rdata_i = 64'h0;
    rst_ni = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
    go_i = 1'b0; resume_i = 1'b0;
    repeat (3) @(negedge clk_i);
    test_reset();
    test_rom();
    test_flags();
    test_pulses();
    test_errors();
    test_abort();
    test_reset_in_resp();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
